// File: rtl/trdb_trace_ctrl.sv
// Trace-session controller: Moore FSM with outputs one cycle after a sampled request; the pkt_req_o/pkt_type_o pair is held until pkt_ack_i and dropped early only on abort.
// `define TRDB_RESYNC_EN adds the RESYNC state and the periodic resync counter.
module trdb_trace_ctrl #(
    parameter int RESYNC_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                trace_activated_i,
    input  logic                trace_req_on_i,
    input  logic                trace_req_off_i,
    input  logic [RESYNC_W-1:0] resync_max_i,
    output logic                pkt_req_o,
    output logic [1:0]          pkt_type_o,
    input  logic                pkt_ack_i,
    output logic                trace_enable_o,
    output logic                busy_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        TRACING = 3'd2,
        STOP    = 3'd3
`ifdef TRDB_RESYNC_EN
        , RESYNC = 3'd4
`endif
    } state_t;

    state_t state, state_nxt;
    logic   stop_pend, stop_pend_nxt;

`ifdef TRDB_RESYNC_EN
    localparam logic [RESYNC_W-1:0] ONE = RESYNC_W'(1);
    logic [RESYNC_W-1:0] cnt, cnt_nxt;
    logic                resync_hit;

    // >= so that lowering the period mid-session fires promptly
    assign resync_hit = (resync_max_i != '0) && (cnt >= resync_max_i - ONE);

    always_comb begin
        cnt_nxt = '0;
        if (state == TRACING && state_nxt == TRACING)
            cnt_nxt = (cnt == '1) ? cnt : cnt + ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt <= '0;
        else         cnt <= cnt_nxt;
    end
`else
    logic unused_resync_max;
    assign unused_resync_max = ^resync_max_i;
`endif

    always_comb begin
        state_nxt     = state;
        stop_pend_nxt = stop_pend;
        case (state)
            IDLE: begin
                if (trace_req_on_i && !trace_req_off_i) state_nxt = START;
            end
`ifdef TRDB_RESYNC_EN
            START, RESYNC: begin
`else
            START: begin
`endif
                if (pkt_ack_i)
                    state_nxt = (stop_pend || trace_req_off_i) ? STOP : TRACING;
                else if (trace_req_off_i)
                    stop_pend_nxt = 1'b1;
            end
            TRACING: begin
                if (trace_req_off_i) state_nxt = STOP;
`ifdef TRDB_RESYNC_EN
                else if (resync_hit) state_nxt = RESYNC;
`endif
            end
            STOP: begin
                if (pkt_ack_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // deactivation withdraws any pending request without waiting for ack
        if (!trace_activated_i) state_nxt = IDLE;
        if (state_nxt == STOP || state_nxt == IDLE) stop_pend_nxt = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            stop_pend <= stop_pend_nxt;
        end
    end

    always_comb begin
        pkt_req_o  = 1'b0;
        pkt_type_o = 2'b00;
        case (state)
            START: pkt_req_o = 1'b1;
            STOP: begin
                pkt_req_o  = 1'b1;
                pkt_type_o = 2'b01;
            end
`ifdef TRDB_RESYNC_EN
            RESYNC: begin
                pkt_req_o  = 1'b1;
                pkt_type_o = 2'b10;
            end
`endif
            default: ;
        endcase
    end

    assign trace_enable_o = (state != IDLE);
    assign busy_o         = (state != IDLE);

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// Bench for trdb_trace_ctrl: session-level reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_trdb_trace_ctrl;
    localparam int W = 16;
`ifdef TRDB_RESYNC_EN
    localparam bit RES_EN = 1'b1;
`else
    localparam bit RES_EN = 1'b0;
`endif
    localparam int NONE = -1, PK_START = 0, PK_STOP = 1, PK_RESYNC = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         act, on, off, ack;
    logic [W-1:0] rmax;
    logic         req, en, busy;
    logic [1:0]   typ;

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // model of the session: active flag, the outstanding framing packet, cycles traced
    bit m_active, m_sp;
    int m_pend, m_tcnt;

    always #5 clk = ~clk;

    trdb_trace_ctrl #(.RESYNC_W(W)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .trace_activated_i (act),
        .trace_req_on_i    (on),
        .trace_req_off_i   (off),
        .resync_max_i      (rmax),
        .pkt_req_o         (req),
        .pkt_type_o        (typ),
        .pkt_ack_i         (ack),
        .trace_enable_o    (en),
        .busy_o            (busy)
    );

    function automatic void model_reset();
        m_active = 1'b0;
        m_sp     = 1'b0;
        m_pend   = NONE;
        m_tcnt   = 0;
    endfunction

    function automatic void model_step();
        if (!act) begin
            model_reset();
        end else if (!m_active) begin
            if (on && !off) begin
                m_active = 1'b1;
                m_pend   = PK_START;
            end
        end else if (m_pend == PK_STOP) begin
            if (ack) begin
                m_active = 1'b0;
                m_pend   = NONE;
            end
        end else if (m_pend != NONE) begin
            if (ack) begin
                if (m_sp || off) begin
                    m_pend = PK_STOP;
                    m_sp   = 1'b0;
                end else begin
                    m_pend = NONE;
                    m_tcnt = 0;
                end
            end else if (off) begin
                m_sp = 1'b1;
            end
        end else begin
            if (off)
                m_pend = PK_STOP;
            else if (RES_EN && rmax != 0 && m_tcnt + 1 >= int'(rmax))
                m_pend = PK_RESYNC;
            else
                m_tcnt++;
        end
    endfunction

    function automatic logic [4:0] model_vec();
        logic       r;
        logic [1:0] t;
        r = (m_pend != NONE);
        t = r ? 2'(m_pend) : 2'b00;
        return {r, t, m_active, m_active};
    endfunction

    function automatic logic [4:0] dut_vec();
        return {req, typ, en, busy};
    endfunction

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: {req,type,en,busy} got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // literal expectation applied to both the DUT and the model
    task automatic lit(input string name, input logic [4:0] exp);
        chk({name, "/dut"}, dut_vec(), exp);
        chk({name, "/model"}, model_vec(), exp);
    endtask

    always @(posedge clk) if (rst_n) model_step();

    always @(negedge clk) if (rst_n && cmp_en) chk("cycle", dut_vec(), model_vec());

    task automatic tick(input bit o_n, input bit o_f, input bit a_k);
        on  = o_n;
        off = o_f;
        ack = a_k;
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [4:0] V_IDLE  = 5'b0_00_0_0;
    localparam logic [4:0] V_START = 5'b1_00_1_1;
    localparam logic [4:0] V_TRACE = 5'b0_00_1_1;
    localparam logic [4:0] V_STOP  = 5'b1_01_1_1;
    localparam logic [4:0] V_RSYNC = RES_EN ? 5'b1_10_1_1 : 5'b0_00_1_1;

    logic [W-1:0] periods [6];

    initial begin
        periods = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
        act = 1'b1; on = 1'b0; off = 1'b0; ack = 1'b0; rmax = '0;
        rst_n = 1'b0;
        model_reset();
        #12;
        lit("reset", V_IDLE);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // full session: on in cycle 2, ack 3 cycles after each request, off in cycle 10
        tick(0, 0, 0);
        tick(1, 0, 0);
        lit("sess_start", V_START);
        tick(0, 0, 0);
        tick(0, 0, 0);
        lit("sess_start_held", V_START);
        tick(0, 0, 1);
        lit("sess_tracing", V_TRACE);
        repeat (4) tick(0, 0, 0);
        tick(0, 1, 0);
        lit("sess_stop", V_STOP);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 1);
        lit("sess_idle", V_IDLE);

        // periodic resync with period 4 and immediate acks
        rmax = 16'd4;
        tick(1, 0, 1);
        tick(0, 0, 1);
        lit("rs_trace0", V_TRACE);
        repeat (4) tick(0, 0, 1);
        lit("rs_first", V_RSYNC);
        tick(0, 0, 1);
        lit("rs_back", V_TRACE);
        repeat (4) tick(0, 0, 1);
        lit("rs_second", V_RSYNC);
        tick(0, 1, 1);
        lit("rs_stop", V_STOP);
        tick(0, 0, 1);
        lit("rs_idle", V_IDLE);

        // off during START becomes a pending stop
        rmax = '0;
        tick(1, 0, 0);
        tick(0, 1, 0);
        lit("pend_start", V_START);
        tick(0, 0, 1);
        lit("pend_stop", V_STOP);
        tick(0, 0, 1);
        lit("pend_idle", V_IDLE);

        // simultaneous events
        tick(1, 1, 0);
        lit("onoff_idle", V_IDLE);
        rmax = 16'd1;
        tick(1, 0, 1);
        tick(0, 0, 1);
        lit("sim_trace", V_TRACE);
        tick(0, 1, 0);
        lit("off_over_resync", V_STOP);
        tick(1, 0, 0);
        lit("on_in_stop", V_STOP);
        tick(1, 0, 1);
        lit("stop_ack_idle", V_IDLE);
        tick(0, 0, 0);
        lit("on_dropped", V_IDLE);

        // abort while a resync request is pending, then confirm the counter restarts
        rmax = 16'd2;
        tick(1, 0, 1);
        tick(0, 0, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        lit("abort_pre", V_RSYNC);
        act = 1'b0;
        tick(0, 0, 0);
        lit("abort_idle", V_IDLE);
        act = 1'b1;
        tick(1, 0, 1);
        tick(0, 0, 1);
        tick(0, 0, 0);
        lit("abort_cnt1", V_TRACE);
        tick(0, 0, 0);
        lit("abort_cnt2", V_RSYNC);
        act = 1'b0;
        tick(0, 0, 0);
        act = 1'b1;

        // reset in the middle of a STOP handshake
        rmax = '0;
        tick(1, 0, 1);
        tick(0, 0, 1);
        tick(0, 1, 0);
        lit("rst_pre", V_STOP);
        rst_n = 1'b0;
        model_reset();
        #1;
        lit("rst_mid", V_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1, 0, 0);
        lit("rst_restart", V_START);
        tick(0, 0, 1);
        tick(0, 1, 1);
        tick(0, 0, 1);
        lit("rst_end", V_IDLE);

        // randomized traffic, checked every cycle against the model
        repeat (3000) begin
            if ($urandom_range(0, 49) == 0) rmax = periods[$urandom_range(0, 5)];
            act = ($urandom_range(0, 99) < 97);
            tick($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 45);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
